// File: rtl/jt89_pkg.sv
// Shared constants and types for the JT89 control block.
package jt89_pkg;

  // Register select encodings carried by the latch byte din[6:4]
  localparam logic [2:0] SEL_TONE0 = 3'd0;
  localparam logic [2:0] SEL_VOL0  = 3'd1;
  localparam logic [2:0] SEL_TONE1 = 3'd2;
  localparam logic [2:0] SEL_VOL1  = 3'd3;
  localparam logic [2:0] SEL_TONE2 = 3'd4;
  localparam logic [2:0] SEL_VOL2  = 3'd5;
  localparam logic [2:0] SEL_NOISE = 3'd6;
  localparam logic [2:0] SEL_VOL3  = 3'd7;

  localparam int         BUSY_CYCLES = 32;
  localparam int         CLK_DIV     = 16;
  localparam int         BCNT_W      = $clog2(BUSY_CYCLES);
  localparam int         DCNT_W      = $clog2(CLK_DIV);
  localparam logic [3:0] VOL_SILENT  = 4'hF;

  typedef enum logic {ST_IDLE, ST_BUSY} busy_st_e;

  // Even selects are tone periods, except 6 which is the noise control
  function automatic logic is_tone(input logic [2:0] s);
    return (s[0] == 1'b0) && (s != SEL_NOISE);
  endfunction

endpackage

// File: rtl/jt89_ctrl_div.sv
// Free-running divide-by-CLK_DIV of clk_en producing the channel clock enable.
module jt89_ctrl_div
  import jt89_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  output logic div_en
);

  logic [DCNT_W-1:0] dcnt;

  // Count clk_en; flag the wrap one clk later as a registered pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt   <= '0;
      div_en <= 1'b0;
    end else begin
      div_en <= clk_en && (dcnt == DCNT_W'(CLK_DIV - 1));
      if (clk_en) dcnt <= dcnt + 1'b1;
    end
  end

endmodule

// File: rtl/jt89_ctrl.sv
// JT89 register file, CPU write decode and write-busy emulation.
module jt89_ctrl
  import jt89_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] din,
  input  logic       wr_n,
  output logic       ready,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] ctrl3,
  output logic       noise_clr,
  output logic       div_en
);

  busy_st_e          st, st_nxt;
  logic [BCNT_W-1:0] bcnt;
  logic              wr_n_l;
  logic              capture;
  logic [2:0]        sel, tgt;
  logic [1:0]        idx;
  logic [2:0][9:0]   tone;
  logic [3:0][3:0]   vol;

  // Latch bytes address themselves; data bytes go to the last latched select.
  // Tone and volume selects share the upper two bits as channel index.
  assign capture = !wr_n && wr_n_l && (st == ST_IDLE);
  assign tgt     = din[7] ? din[6:4] : sel;
  assign idx     = tgt[2:1];
  assign ready   = (st == ST_IDLE);

  // Busy FSM next state: 32 clk_en after a capture before accepting again
  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE: if (capture) st_nxt = ST_BUSY;
      ST_BUSY: if (clk_en && bcnt == BCNT_W'(BUSY_CYCLES - 1)) st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  // Busy state, busy counter and write strobe history
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= ST_IDLE;
      bcnt   <= '0;
      wr_n_l <= 1'b1;
    end else begin
      st     <= st_nxt;
      wr_n_l <= wr_n;
      if (capture)                      bcnt <= '0;
      else if (st == ST_BUSY && clk_en) bcnt <= bcnt + 1'b1;
    end
  end

  // Register file update on an accepted write
  always_ff @(posedge clk) begin
    if (rst) begin
      sel       <= '0;
      tone      <= '0;
      vol       <= {4{VOL_SILENT}};
      ctrl3     <= '0;
      noise_clr <= 1'b0;
    end else begin
      noise_clr <= 1'b0;
      if (capture) begin
        if (din[7]) sel <= din[6:4];
        if (is_tone(tgt)) begin
          for (int i = 0; i < 3; i++) begin
            if (idx == 2'(i)) begin
              if (din[7]) tone[i][3:0] <= din[3:0];
              else        tone[i][9:4] <= din[5:0];
            end
          end
        end else if (tgt == SEL_NOISE) begin
          ctrl3     <= din[2:0];
          noise_clr <= 1'b1;
        end else begin
          vol[idx] <= din[3:0];
        end
      end
    end
  end

  assign tone0 = tone[0];
  assign tone1 = tone[1];
  assign tone2 = tone[2];
  assign vol0  = vol[0];
  assign vol1  = vol[1];
  assign vol2  = vol[2];
  assign vol3  = vol[3];

  jt89_ctrl_div u_div (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .div_en (div_en)
  );

endmodule

// File: tb/tb_jt89_ctrl.sv
// Directed self-checking bench for jt89_ctrl.
module tb_jt89_ctrl;

  logic       clk = 1'b0;
  logic       rst, clk_en, wr_n;
  logic [7:0] din;
  logic       ready, noise_clr, div_en;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] ctrl3;

  int n_chk  = 0;
  int n_pass = 0;
  int pulses;

  jt89_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .din       (din),
    .wr_n      (wr_n),
    .ready     (ready),
    .tone0     (tone0),
    .tone1     (tone1),
    .tone2     (tone2),
    .vol0      (vol0),
    .vol1      (vol1),
    .vol2      (vol2),
    .vol3      (vol3),
    .ctrl3     (ctrl3),
    .noise_clr (noise_clr),
    .div_en    (div_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clk with the given clk_en; outputs are sampled 1ns after the edge
  task automatic step(input logic en);
    clk_en = en;
    @(posedge clk);
    #1;
    clk_en = 1'b0;
  endtask

  // Single-cycle falling edge on wr_n, then release
  task automatic wr(input logic [7:0] b);
    din  = b;
    wr_n = 1'b0;
    step(1'b0);
    chk("ready_low_after_capture", 16'(ready), 16'd0);
    wr_n = 1'b1;
    step(1'b0);
  endtask

  // Expect busy for exactly 32 clk_en, ready rising after the 32nd
  task automatic busy_wait(input string tag);
    for (int k = 1; k <= 32; k++) begin
      step(1'b1);
      if (k == 31) chk({tag, "_ready_k31"}, 16'(ready), 16'd0);
    end
    chk({tag, "_ready_k32"}, 16'(ready), 16'd1);
  endtask

  initial begin
    rst = 1'b1; wr_n = 1'b1; din = 8'h00; clk_en = 1'b0;
    step(1'b0);
    step(1'b1);
    rst = 1'b0;

    // Reset state
    chk("rst_tone0", 16'(tone0), 16'h000);
    chk("rst_tone1", 16'(tone1), 16'h000);
    chk("rst_tone2", 16'(tone2), 16'h000);
    chk("rst_vols",  {vol0, vol1, vol2, vol3}, 16'hFFFF);
    chk("rst_ctrl3", 16'(ctrl3), 16'h0);
    chk("rst_ready", 16'(ready), 16'h1);
    chk("rst_nclr",  16'(noise_clr), 16'h0);
    chk("rst_div",   16'(div_en), 16'h0);

    // Divider: 64 clk_en, pulse one clk after each 16th, each one clk wide
    pulses = 0;
    for (int k = 1; k <= 64; k++) begin
      step(1'b1);
      if (div_en) pulses++;
      if (k % 16 == 0) chk($sformatf("div_pulse_%0d", k), 16'(div_en), 16'h1);
      if (k % 16 == 1) chk($sformatf("div_idle_%0d", k), 16'(div_en), 16'h0);
      step(1'b0);
      if (k % 16 == 0) chk($sformatf("div_width_%0d", k), 16'(div_en), 16'h0);
    end
    chk("div_count", 16'(pulses), 16'd4);

    // Tone0 latch then data
    wr(8'h8A);
    chk("tone0_latch", 16'(tone0), 16'h00A);
    busy_wait("t0l");
    wr(8'h3F);
    chk("tone0_data", 16'(tone0), 16'h3FA);
    busy_wait("t0d");

    // Tone1 latch then data, tone0 untouched
    wr(8'hA5);
    busy_wait("t1l");
    wr(8'h01);
    chk("tone1_data", 16'(tone1), 16'h015);
    chk("tone0_keep", 16'(tone0), 16'h3FA);
    busy_wait("t1d");

    // Vol2 via latch bytes
    wr(8'hD3);
    chk("vol2_3", 16'(vol2), 16'h3);
    busy_wait("v2a");
    wr(8'hDF);
    chk("vol2_F", 16'(vol2), 16'hF);
    busy_wait("v2b");

    // Vol3 latch then data byte
    wr(8'hF2);
    busy_wait("v3l");
    wr(8'h09);
    chk("vol3_data", 16'(vol3), 16'h9);
    chk("vol_others", {vol0, vol1, vol2}, 16'h0FFF);
    busy_wait("v3d");

    // Noise latch and data: one-clk noise_clr pulse each
    din = 8'hE5; wr_n = 1'b0;
    step(1'b0);
    chk("ctrl3_latch", 16'(ctrl3), 16'h5);
    chk("nclr_hi_1", 16'(noise_clr), 16'h1);
    wr_n = 1'b1;
    step(1'b0);
    chk("nclr_lo_1", 16'(noise_clr), 16'h0);
    busy_wait("nl");
    din = 8'h06; wr_n = 1'b0;
    step(1'b1);
    chk("ctrl3_data", 16'(ctrl3), 16'h6);
    chk("nclr_hi_2", 16'(noise_clr), 16'h1);
    wr_n = 1'b1;
    step(1'b0);
    chk("nclr_lo_2", 16'(noise_clr), 16'h0);
    // capture coincided with clk_en: still 32 further clk_en of busy
    busy_wait("nd");

    // Busy drop: second edge 10 clk_en in is ignored, wr_n held low after
    wr(8'h81);
    chk("tone0_81", 16'(tone0), 16'h3F1);
    for (int k = 1; k <= 10; k++) step(1'b1);
    din = 8'h8F; wr_n = 1'b0;
    for (int k = 11; k <= 32; k++) begin
      step(1'b1);
      if (k == 31) chk("drop_ready_k31", 16'(ready), 16'd0);
    end
    chk("drop_ready_k32", 16'(ready), 16'd1);
    chk("drop_tone0", 16'(tone0), 16'h3F1);
    step(1'b0);
    chk("drop_no_retrig", 16'(ready), 16'd1);
    chk("drop_tone0_b", 16'(tone0), 16'h3F1);
    wr_n = 1'b1;
    step(1'b0);

    // Edge in the cycle ready has just risen is accepted
    wr(8'hB7);
    for (int k = 1; k <= 32; k++) step(1'b1);
    chk("rise_ready", 16'(ready), 16'd1);
    din = 8'h90; wr_n = 1'b0;
    step(1'b0);
    chk("rise_vol0", 16'(vol0), 16'h0);
    chk("rise_busy", 16'(ready), 16'd0);
    chk("vol1_B7",   16'(vol1), 16'h7);
    wr_n = 1'b1;

    // Reset mid-BUSY at bcnt=12, with a write edge in the reset cycle
    for (int k = 1; k <= 12; k++) step(1'b1);
    chk("pre_rst_busy", 16'(ready), 16'd0);
    rst = 1'b1; din = 8'h83; wr_n = 1'b0;
    step(1'b0);
    rst = 1'b0; wr_n = 1'b1;
    chk("mid_rst_ready", 16'(ready), 16'd1);
    chk("mid_rst_tones", 16'(tone0 | tone1 | tone2), 16'h000);
    chk("mid_rst_vols",  {vol0, vol1, vol2, vol3}, 16'hFFFF);
    chk("mid_rst_ctrl3", 16'(ctrl3), 16'h0);
    step(1'b0);
    chk("post_rst_tone0", 16'(tone0), 16'h000);
    chk("post_rst_ready", 16'(ready), 16'd1);
    chk("post_rst_nclr",  16'(noise_clr), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jt89_ctrl.md
# jt89_ctrl

Register-file and write sequencer for the JT89 PSG. It accepts the CPU byte-write protocol (latch byte followed by optional data byte) and decodes it into the per-channel configuration: three 10-bit tone periods, four 4-bit attenuations, and the 3-bit noise control plus its LFSR clear pulse. It emulates the chip's write-busy window with a READY handshake and derives the divide-by-16 channel clock enable. The block sits between the bus interface and the tone/noise/volume channel modules.

## Interface
- Parameters: none; constants come from `jt89_pkg`.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `clk_en` in 1: chip clock enable, one clk wide per PSG master tick.
- `din` in 8: CPU write data.
- `wr_n` in 1: active-low write strobe, asynchronous to `clk_en`, synchronous to `clk`.
- `ready` out 1: high when a new write is accepted.
- `tone0`, `tone1`, `tone2` out 10 each: tone period registers.
- `vol0`, `vol1`, `vol2`, `vol3` out 4 each: attenuation; `4'hF` means silent.
- `ctrl3` out 3: noise control; bit 2 selects white noise, bits 1:0 select the rate.
- `noise_clr` out 1: one-clk pulse that resets the noise LFSR.
- `div_en` out 1: channel clock enable, one pulse per 16 `clk_en`.

## Operation
- Write capture: `wr_n_l` is registered every clk and is not gated by `clk_en`.
  - A capture happens at the clk edge where `wr_n==0 && wr_n_l==1 && ready==1`.
  - An edge seen while `ready==0` is dropped. It is not queued, and holding `wr_n` low afterwards does not retrigger it.
- Latch byte (`din[7]=1`):
  - `sel <= din[6:4]`.
  - Tone select (0, 2, 4): `tone[3:0] <= din[3:0]`.
  - Vol select (1, 3, 5, 7): `vol <= din[3:0]`.
  - Noise select (6): `ctrl3 <= din[2:0]` and pulse `noise_clr`.
- Data byte (`din[7]=0`) targets the latched `sel`:
  - Tone: `tone[9:4] <= din[5:0]`; `tone[3:0]` is unchanged.
  - Vol: `vol <= din[3:0]`.
  - Noise: `ctrl3 <= din[2:0]` and pulse `noise_clr`.
- Register select encoding: 0=tone0, 1=vol0, 2=tone1, 3=vol1, 4=tone2, 5=vol2, 6=noise, 7=vol3.
- Busy FSM has two states:
  - IDLE (`ready=1`): a capture moves to BUSY and clears `bcnt`.
  - BUSY (`ready=0`): `bcnt` (5 bits) increments on each `clk_en`. On the `clk_en` where `bcnt==31`, the FSM moves to IDLE, which gives exactly 32 `clk_en` pulses of busy.
- Divider: a 4-bit `dcnt` increments on `clk_en`. `div_en` is registered and is high for one clk on the cycle after the `clk_en` that wraps `dcnt` from 15 to 0. The divider free-runs and is independent of writes.
- Reset values:
  - `tone0`..`tone2` = 0.
  - `vol0`..`vol3` = `4'hF`.
  - `ctrl3` = 0, `sel` = 0.
  - `ready` = 1 (IDLE).
  - `noise_clr` = 0, `div_en` = 0.
  - `bcnt` = 0, `dcnt` = 0, `wr_n_l` = 1.
- Reset mid-BUSY: returns to IDLE with `ready=1` on the next cycle. A write edge in the same cycle as `rst` is ignored.

## Timing
- Capture at edge N:
  - Register outputs and `sel` show their new values after edge N.
  - `ready` is low after edge N.
  - `noise_clr` is high for exactly the cycle between edges N and N+1, independent of `clk_en`.
- `ready` rises one clk after the 32nd `clk_en` following the capture. A falling edge of `wr_n` in the cycle where `ready` has just gone high is accepted.
- A capture coinciding with `clk_en` does not count that `clk_en` toward the 32.
- `div_en` phase is fixed by reset. The first pulse follows the 16th `clk_en` after reset.
- Simultaneous capture and `div_en`: both take effect with no interaction.

## Structure
- `jt89_pkg` holds:
  - the `sel` encodings `SEL_TONE0` through `SEL_VOL3`;
  - `BUSY_CYCLES=32`;
  - `CLK_DIV=16`;
  - `VOL_SILENT=4'hF`.
- Sub-module `jt89_ctrl_div` holds the 4-bit `clk_en` divider that produces `div_en`. The write decode and busy FSM stay in `jt89_ctrl`.

## Test plan
- Reset state: after `rst`, all tones read 0, all vols read F, `ctrl3` reads 0, `ready` is 1, and no `noise_clr` or `div_en` pulse occurs.
- Tone write: latch `0x8A` then data `0x3F` to tone0 → `tone0=0x3FA`; `ready` is low for 32 `clk_en` after each byte.
- Vol and noise: latch `0xDF` → `vol2=0xF`; latch `0xE5` → `ctrl3=5` and one `noise_clr` pulse; data byte `0x06` with `sel`=noise → `ctrl3=6` and a second pulse.
- Busy drop: second `wr_n` falling edge 10 `clk_en` after the first → registers unchanged and `ready` timing unaffected.
- `div_en`: run 64 `clk_en` → exactly 4 `div_en` pulses, each one clk wide and one clk after `clk_en` number 16, 32, 48, 64.
- Reset mid-BUSY: assert `rst` with `bcnt=12` → `ready=1` on the next cycle, and all registers return to their reset values.
